// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined integer multiplier: opcode encodings
// and the rows-per-stage helper.
package mul_pkg;

    localparam logic [5:0] OP_MUL    = 6'b001_000;
    localparam logic [5:0] OP_MULH   = 6'b001_001;
    localparam logic [5:0] OP_MULHSU = 6'b001_010;
    localparam logic [5:0] OP_MULHU  = 6'b001_011;

    function automatic int unsigned rows_per_stage(input int unsigned w_data,
                                                   input int unsigned n_stg);
        return (2 * w_data) / n_stg;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One multiplier pipeline stage: valid bit, payload registers and the adder
// that folds this stage's L partial-product rows into the running sum.
// Optional flush input present when MUL_FLUSH_EN is defined.
module mul_pipe_stage
    import mul_pkg::*;
#(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned W_UOPS = 6,
    parameter int unsigned W_TAG  = 5,
    parameter int unsigned S_ID   = 0,
    parameter int unsigned L      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef MUL_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  adv,
    input  logic                  v_in,
    input  logic [W_UOPS-1:0]     uops_in,
    input  logic [W_TAG-1:0]      tag_in,
    input  logic [2*W_DATA-1:0]   rs_in,
    input  logic [2*W_DATA-1:0]   rt_in,
    input  logic [2*W_DATA-1:0]   acc_in,
    output logic                  v,
    output logic [W_UOPS-1:0]     uops,
    output logic [W_TAG-1:0]      tag,
    output logic [2*W_DATA-1:0]   rs,
    output logic [2*W_DATA-1:0]   rt,
    output logic [2*W_DATA-1:0]   acc_out
);

    localparam int unsigned W2 = 2 * W_DATA;

    logic [W2-1:0] rs_d;
    logic [W2-1:0] rt_d;
    logic [W2-1:0] acc_q;

    generate
        if (S_ID == 0) begin : g_ext
            logic sx_rs;
            logic sx_rt;

            always_comb begin
                sx_rs = 1'b0;
                sx_rt = 1'b0;
                if (uops_in == W_UOPS'(OP_MULH)) begin
                    sx_rs = rs_in[W_DATA-1];
                    sx_rt = rt_in[W_DATA-1];
                end else if (uops_in == W_UOPS'(OP_MULHSU)) begin
                    sx_rs = rs_in[W_DATA-1];
                end
            end

            // Upper half arrives as zero; OR-ing in the sign fill extends it.
            assign rs_d = rs_in | ({W2{sx_rs}} << W_DATA);
            assign rt_d = rt_in | ({W2{sx_rt}} << W_DATA);
        end else begin : g_pass
            assign rs_d = rs_in;
            assign rt_d = rt_in;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= 1'b0;
            uops  <= '0;
            tag   <= '0;
            rs    <= '0;
            rt    <= '0;
            acc_q <= '0;
        end else begin
`ifdef MUL_FLUSH_EN
            if (flush) v <= 1'b0;
            else if (adv) v <= v_in;
`else
            if (adv) v <= v_in;
`endif
            if (adv && v_in) begin
                uops  <= uops_in;
                tag   <= tag_in;
                rs    <= rs_d;
                rt    <= rt_d;
                acc_q <= acc_in;
            end
        end
    end

    always_comb begin
        acc_out = acc_q;
        for (int unsigned j = 0; j < L; j++) begin
            if (rt[S_ID*L + j]) acc_out = acc_out + (rs << (S_ID*L + j));
        end
    end

endmodule

// File: rtl/mul_pipe_hs.sv
// Fully pipelined RV-style MUL/MULH/MULHSU/MULHU unit with per-stage valid
// handshake. Define MUL_FLUSH_EN to add the flush port.
module mul_pipe_hs
    import mul_pkg::*;
#(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned N_STG  = 4,
    parameter int unsigned W_UOPS = 6,
    parameter int unsigned W_TAG  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MUL_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_UOPS-1:0] in_uops,
    input  logic [W_DATA-1:0] in_rs,
    input  logic [W_DATA-1:0] in_rt,
    input  logic [W_TAG-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_UOPS-1:0] out_uops,
    output logic [W_TAG-1:0]  out_tag,
    output logic [W_DATA-1:0] out_rd,
    output logic              busy
);

    localparam int unsigned W2 = 2 * W_DATA;
    localparam int unsigned L  = rows_per_stage(W_DATA, N_STG);

    // Index 0 carries the request; index k+1 carries stage k's outputs.
    logic              v_a    [N_STG+1];
    logic [W_UOPS-1:0] uops_a [N_STG+1];
    logic [W_TAG-1:0]  tag_a  [N_STG+1];
    logic [W2-1:0]     rs_a   [N_STG+1];
    logic [W2-1:0]     rt_a   [N_STG+1];
    logic [W2-1:0]     acc_a  [N_STG+1];
    logic [N_STG:0]    adv;

    assign v_a[0]    = in_valid;
    assign uops_a[0] = in_uops;
    assign tag_a[0]  = in_tag;
    assign rs_a[0]   = {{W_DATA{1'b0}}, in_rs};
    assign rt_a[0]   = {{W_DATA{1'b0}}, in_rt};
    assign acc_a[0]  = '0;
    assign adv[N_STG] = out_ready;

    for (genvar k = 0; k < N_STG; k++) begin : g_stg
        assign adv[k] = !v_a[k+1] || adv[k+1];

        mul_pipe_stage #(
            .W_DATA (W_DATA),
            .W_UOPS (W_UOPS),
            .W_TAG  (W_TAG),
            .S_ID   (k),
            .L      (L)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
`ifdef MUL_FLUSH_EN
            .flush   (flush),
`endif
            .adv     (adv[k]),
            .v_in    (v_a[k]),
            .uops_in (uops_a[k]),
            .tag_in  (tag_a[k]),
            .rs_in   (rs_a[k]),
            .rt_in   (rt_a[k]),
            .acc_in  (acc_a[k]),
            .v       (v_a[k+1]),
            .uops    (uops_a[k+1]),
            .tag     (tag_a[k+1]),
            .rs      (rs_a[k+1]),
            .rt      (rt_a[k+1]),
            .acc_out (acc_a[k+1])
        );
    end

`ifdef MUL_FLUSH_EN
    assign in_ready = adv[0] && !flush;
`else
    assign in_ready = adv[0];
`endif

    always_comb begin
        busy = 1'b0;
        for (int unsigned k = 1; k <= N_STG; k++) busy = busy | v_a[k];
    end

    assign out_valid = v_a[N_STG];
    assign out_uops  = uops_a[N_STG];
    assign out_tag   = tag_a[N_STG];

    always_comb begin
        out_rd = '0;
        case (out_uops)
            W_UOPS'(OP_MUL):    out_rd = acc_a[N_STG][W_DATA-1:0];
            W_UOPS'(OP_MULH),
            W_UOPS'(OP_MULHSU),
            W_UOPS'(OP_MULHU):  out_rd = acc_a[N_STG][W2-1:W_DATA];
            default:            out_rd = '0;
        endcase
    end

endmodule

// File: tb/tb_mul_pipe_hs.sv
// Self-checking bench for mul_pipe_hs: randomized traffic against a queue
// scoreboard with an arithmetic reference; flush scenario under MUL_FLUSH_EN.
module tb_mul_pipe_hs;

    localparam logic [5:0] C_MUL    = 6'b001_000;
    localparam logic [5:0] C_MULH   = 6'b001_001;
    localparam logic [5:0] C_MULHSU = 6'b001_010;
    localparam logic [5:0] C_MULHU  = 6'b001_011;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_uops;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_uops;
    logic [4:0]  out_tag;
    logic [31:0] out_rd;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [42:0] exp_q[$];
    int          cyc = 0;
    int          n_emit = 0;
    int          first_emit = 0;
    int          last_emit = 0;
    logic        saw_stall = 1'b0;
    logic        hold_prev = 1'b0;
    logic [43:0] prev_out;

    always #5 clk = ~clk;

    mul_pipe_hs #(
        .W_DATA (32),
        .N_STG  (NS),
        .W_UOPS (6),
        .W_TAG  (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUL_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_uops   (in_uops),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_uops  (out_uops),
        .out_tag   (out_tag),
        .out_rd    (out_rd),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      x;
        longint      y;
        logic [63:0] p;
        case (op)
            C_MUL:    begin p = 64'(a) * 64'(b); return p[31:0]; end
            C_MULH:   begin x = longint'($signed(a)); y = longint'($signed(b));
                            p = 64'(x * y); return p[63:32]; end
            C_MULHSU: begin x = longint'($signed(a)); y = longint'({32'b0, b});
                            p = 64'(x * y); return p[63:32]; end
            C_MULHU:  begin p = 64'(a) * 64'(b); return p[63:32]; end
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        int unsigned r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    return C_MUL;
            2, 3:    return C_MULH;
            4, 5:    return C_MULHSU;
            6, 7:    return C_MULHU;
            8:       return 6'($urandom);
            default: return C_MUL;
        endcase
    endfunction

    // Scoreboard: occupancy-based handshake expectations plus ordered results.
    always @(negedge clk) begin
        logic        fl;
        logic [42:0] e;
        fl = flush;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            check("in_ready", in_ready, !(exp_q.size() == NS && !out_ready) && !fl);
            check("busy", busy, exp_q.size() != 0);
            if (!in_ready) saw_stall = 1'b1;
            if (hold_prev) check("hold", {out_valid, out_uops, out_tag, out_rd}, prev_out);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {out_uops, out_tag, out_rd}, e);
                    if (n_emit == 0) first_emit = cyc;
                    last_emit = cyc;
                    n_emit++;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({in_uops, in_tag, ref_rd(in_uops, in_rs, in_rt)});
            hold_prev = out_valid && !out_ready && !fl;
            prev_out  = {out_valid, out_uops, out_tag, out_rd};
            if (fl) exp_q.delete();
        end
    end

    task automatic push_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tg);
        in_valid = 1'b1;
        in_uops  = op;
        in_rs    = a;
        in_rt    = b;
        in_tag   = tg;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_dir(input string nm, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int lat;
        push_req(op, a, b, 5'd9);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        check({nm, "_rd"}, out_rd, exp);
        check({nm, "_lat"}, lat, NS);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic stream16();
        for (int i = 0; i < 16; i++) push_req(pick_op(), $urandom, $urandom, 5'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_uops = '0;
        in_rs = '0; in_rt = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_rd", out_rd, 32'h0);
        check("rst_out_uops", out_uops, 6'h0);
        check("rst_out_tag", out_tag, 5'h0);
        @(posedge clk);
        #1;

        run_dir("mul_7x6", C_MUL, 32'd7, 32'd6, 32'h0000002A);
        run_dir("mulh_min", C_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
        run_dir("mulh_m1", C_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_dir("mulhsu_m1", C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_dir("mulhu_max", C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_dir("illegal_op", 6'b111_111, 32'h1234, 32'h5678, 32'h0);

        n_emit = 0;
        stream16();
        drain();
        check("stream_count", n_emit, 16);
        check("stream_span", last_emit - first_emit, 15);

        n_emit = 0;
        saw_stall = 1'b0;
        fork
            stream16();
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_stalled", saw_stall, 1'b1);
        check("bp_count", n_emit, 16);

        n_emit = 0;
        saw_stall = 1'b0;
        fork
            for (int i = 0; i < 8; i++) begin
                push_req(pick_op(), $urandom, $urandom, 5'(i));
                @(posedge clk);
                #1;
            end
            begin
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bubble_no_stall", saw_stall, 1'b0);
        check("bubble_count", n_emit, 8);

        for (int i = 0; i < 3; i++) push_req(pick_op(), $urandom, $urandom, 5'(20 + i));
        #2;
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

`ifdef MUL_FLUSH_EN
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_req(pick_op(), $urandom, $urandom, 5'(i));
        in_valid = 1'b1; in_uops = C_MUL; in_rs = 32'd9; in_rt = 32'd9; in_tag = 5'd30;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        run_dir("post_flush", C_MUL, 32'd3, 32'd5, 32'd15);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
